ks_adder_pipe: RTL
==================

# ks_adder_pipe

Pipelined, parametrised Kogge-Stone add/subtract unit with a valid/ready handshake and result flags. It is the next-generation datapath adder: it adds a subtract mode, carry/overflow/zero flags, configurable register insertion between prefix levels, and per-stage backpressure. It sits between operand-issue logic and any result consumer that may stall.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥1)
- PIPE_EVERY, 1, number of prefix levels per pipeline stage (≥1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts beat this cycle
- a  in  WIDTH  first operand
- b  in  WIDTH  second operand
- c_in  in  1  carry-in (ADD) / borrow-in (SUB), active-high
- op_sub  in  1  0 = ADD, 1 = SUB
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  sum/difference
- c_out  out  1  raw carry out of MSB (SUB: 1 = no borrow)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  result == 0

## Operation
- Effective operands: b_eff = op_sub ? ~b : b; cin_eff = op_sub ? ~c_in : c_in. ADD: a+b+c_in. SUB: a−b−c_in.
- Level 0 (combinational at input): p0 = a ^ b_eff, g0 = a & b_eff.
- LEVELS = clog2(WIDTH) (0 when WIDTH=1). Level j: bit i with i ≥ 2^(j−1) combines with bit i−2^(j−1): g = g_i | (p_i & g_prev), p = p_i & p_prev; lower bits pass through.
- Carry i = G_i | (P_i & cin_eff); result[0] = p0[0] ^ cin_eff; result[i] = p0[i] ^ carry[i−1]; c_out = carry[WIDTH−1].
- ovf = carry[WIDTH−1] ^ carry[WIDTH−2] (WIDTH=1: ovf = c_out ^ cin_eff). zero = ~|result.
- Stages: NSTG = max(1, ceil(LEVELS/PIPE_EVERY)). Stage k holds prefix levels k·PIPE_EVERY+1 … min((k+1)·PIPE_EVERY, LEVELS) and ends in a register. The last stage also computes result and flags before its register. Each stage register carries p0, current P/G, cin_eff and a valid bit.
- Handshake (bubble-collapsing): stage k loads when !valid[k] or stage k+1 (or consumer, for the last stage) takes its content. in_ready = load enable of stage 0. The beat transfers on in_valid & in_ready; output is consumed on out_valid & out_ready.
- Held output stays stable (result, flags) while out_valid & !out_ready.
- Order is preserved; no beat is dropped or duplicated.

## Timing
- Latency: NSTG cycles from accepted input to out_valid, with no stall. Examples: WIDTH=32 → PIPE_EVERY=1: 5, =2: 3, ≥5: 1. WIDTH=8, PIPE_EVERY=1: 3.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready is combinational from out_ready and the valid bits. There is no combinational path from a/b to outputs.
- Full pipeline with out_ready=0: in_ready=0 after NSTG beats are accepted. A single out_ready pulse frees exactly one slot.
- Simultaneous pop and push on a full pipeline is accepted in the same cycle.
- Reset: all valid bits 0 immediately (asynchronous). out_valid=0, in_ready=1 while out_ready is don't-care, and result/c_out/ovf/zero=0.
- Reset mid-operation: in-flight beats are discarded and no partial result is emitted. After deassertion the first accepted beat appears after NSTG cycles.
- Data registers may be non-reset; output ports must still read 0 during reset (gate with valid or reset data).

## Structure
- Package ks_pkg: function ks_levels(width), function ks_stages(levels, pipe_every), and a typedef for per-stage payload struct {p0, P, G, cin_eff}, parametrised by width via the module.
- Sub-module ks_prefix_level #(WIDTH, DIST): one combinational Kogge-Stone level (pass-through below DIST). It is instantiated LEVELS times and grouped into stages by a generate loop.
- Top: operand conditioning, generate loop of stage registers plus handshake, and final sum/flag logic.

## Test plan
WIDTH=8, PIPE_EVERY=1 unless stated otherwise.
- ADD 0xFF+0x01, c_in=0 → after 3 cycles result=0x00, c_out=1, zero=1, ovf=0.
- ADD 0x7F+0x01, c_in=0 → result=0x80, ovf=1, c_out=0. SUB 0x80−0x01, c_in=0 → 0x7F, ovf=1, c_out=1.
- SUB 0x05−0x07, c_in=0 → 0xFE, c_out=0, ovf=0. SUB 0x05−0x04, c_in=1 → 0x00, zero=1, c_out=1.
- Backpressure: stream 10 random beats with out_ready toggling 1/0 randomly → in_ready=0 only when 3 beats are held; output order and values match the reference model; output is stable during stalls.
- Reset mid-stream: assert rst with 2 beats in flight → out_valid drops asynchronously and outputs read 0. After release, 0x10+0x20 → 0x30 emitted once, 3 cycles later.
- Sweep WIDTH∈{1,5,32,33} × PIPE_EVERY∈{1,2,8} with random ADD/SUB → latency = NSTG and all outputs match the model.

Source files
------------

// File: rtl/ks_adder_pipe_pkg.sv
// Shared helpers for the pipelined Kogge-Stone add/subtract unit.
package ks_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Number of prefix levels needed to span WIDTH bits (0 for a single bit).
  function automatic int unsigned ks_levels(input int unsigned width);
    int unsigned lv;
    lv = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(width)) lv = i + 1;
    end
    return lv;
  endfunction

  // Pipeline stage count; at least one register even with no prefix levels.
  function automatic int unsigned ks_stages(input int unsigned levels,
                                            input int unsigned pipe_every);
    return (levels == 0) ? 1 : (levels + pipe_every - 1) / pipe_every;
  endfunction

endpackage

// File: rtl/ks_adder_pipe_prefix_level.sv
// One combinational Kogge-Stone prefix level; bits below DIST pass through.
module ks_prefix_level #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] g_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < DIST) begin : g_pass
      assign p_o[i] = p_i[i];
      assign g_o[i] = g_i[i];
    end else begin : g_comb
      assign p_o[i] = p_i[i] & p_i[i-DIST];
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
    end
  end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract unit with bubble-collapsing valid/ready
// handshake and carry/overflow/zero flags.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PIPE_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned LEVELS = ks_levels(WIDTH);
  localparam int unsigned NSTG   = ks_stages(LEVELS, PIPE_EVERY);

  typedef struct packed {
    logic [WIDTH-1:0] p0;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] gg;
    logic             cin_eff;
  } stage_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
    logic             zero;
  } res_t;

  op_e              op;
  logic [WIDTH-1:0] b_eff;
  stage_t           in_pl;

  stage_t           sin   [NSTG];
  stage_t           sout  [NSTG];
  stage_t           st_q  [NSTG];
  stage_t           st_d  [NSTG];
  logic [NSTG-1:0]  vld_q;
  logic [NSTG-1:0]  vld_d;
  logic [NSTG-1:0]  ld;
  logic [NSTG:0]    vin;
  res_t             res_c;
  res_t             res_q;
  res_t             res_d;

  // Operand conditioning and level-0 propagate/generate.
  always_comb begin
    in_pl         = '0;
    op            = op_e'(op_sub);
    b_eff         = (op == OP_SUB) ? ~b : b;
    in_pl.cin_eff = (op == OP_SUB) ? ~c_in : c_in;
    in_pl.p0      = a ^ b_eff;
    in_pl.pp      = a ^ b_eff;
    in_pl.gg      = a & b_eff;
  end

  // Per-stage input selection and the prefix levels grouped into that stage.
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int unsigned LO = k * PIPE_EVERY;
    localparam int unsigned HI = ((k + 1) * PIPE_EVERY < LEVELS) ? (k + 1) * PIPE_EVERY : LEVELS;
    localparam int unsigned NL = (HI > LO) ? HI - LO : 0;

    logic [WIDTH-1:0] cp [NL+1];
    logic [WIDTH-1:0] cg [NL+1];

    if (k == 0) begin : g_src_in
      assign sin[k] = in_pl;
    end else begin : g_src_reg
      assign sin[k] = st_q[k-1];
    end

    assign cp[0] = sin[k].pp;
    assign cg[0] = sin[k].gg;

    for (genvar m = 0; m < NL; m++) begin : g_lvl
      ks_prefix_level #(
        .WIDTH (WIDTH),
        .DIST  (32'(1) << (LO + m))
      ) u_lvl (
        .p_i (cp[m]),
        .g_i (cg[m]),
        .p_o (cp[m+1]),
        .g_o (cg[m+1])
      );
    end

    assign sout[k] = '{p0: sin[k].p0, pp: cp[NL], gg: cg[NL], cin_eff: sin[k].cin_eff};
  end

  // Final carries, sum and flags from the fully reduced prefix of the last stage.
  always_comb begin
    logic c_into;
    logic msb_in;
    res_c  = '0;
    c_into = sout[NSTG-1].cin_eff;
    msb_in = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      res_c.result[i] = sout[NSTG-1].p0[i] ^ c_into;
      if (i == WIDTH - 1) msb_in = c_into;
      c_into = sout[NSTG-1].gg[i] | (sout[NSTG-1].pp[i] & sout[NSTG-1].cin_eff);
    end
    res_c.c_out = c_into;
    res_c.ovf   = c_into ^ msb_in;
    res_c.zero  = ~|res_c.result;
  end

  // Load enables: a stage loads when empty or when its content moves on.
  always_comb begin
    logic nxt;
    ld  = '0;
    nxt = out_ready;
    for (int k = int'(NSTG) - 1; k >= 0; k--) begin
      ld[k] = !vld_q[k] | nxt;
      nxt   = ld[k];
    end
  end

  assign vin = {vld_q, in_valid};

  // Next-state for valid bits, stage payloads and the output register.
  always_comb begin
    vld_d = vld_q;
    st_d  = st_q;
    res_d = res_q;
    for (int unsigned k = 0; k < NSTG; k++) begin
      if (ld[k]) begin
        vld_d[k] = vin[k];
        if (vin[k]) st_d[k] = sout[k];
      end
    end
    if (ld[NSTG-1] && vin[NSTG-1]) res_d = res_c;
  end

  // Pipeline state; reset clears valid bits and the visible result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      res_q <= '0;
      for (int unsigned k = 0; k < NSTG; k++) st_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      for (int unsigned k = 0; k < NSTG; k++) st_q[k] <= st_d[k];
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_q[NSTG-1];
  assign result    = res_q.result;
  assign c_out     = res_q.c_out;
  assign ovf       = res_q.ovf;
  assign zero      = res_q.zero;

endmodule
